spi_receiver: RTL and testbench
===============================

// Module: spi_receiver
// PURPOSE
//  Downstream capture stage for the SPI link: receives CS/SCK/MOSI produced by the transmitter,
//  deserialises P_DATA_WIDTH-bit words (MSB first, mode 0: sample on SCK rise), and buffers
//  them in a small FIFO exposed through a valid/ready handshake. Used as the loop-back sink on
//  the board and as the bench checker for the transmit path.
// PARAMETERS
//  P_DATA_WIDTH     8  word width in bits (from config_pkg)
//  P_RX_FIFO_DEPTH  4  words buffered; power of 2, >=2 (from config_pkg)
// PORTS
//  clk_100    in   1             system clock, 100 MHz; the only clock
//  a_rst      in   1             asynchronous, active-low reset
//  sck_in     in   1             SPI clock, async to clk_100, f_sck <= clk_100/4
//  cs_in      in   1             chip select, active low, async
//  mosi_in    in   1             serial data, async
//  data_out   out  P_DATA_WIDTH  FIFO head word
//  valid_out  out  1             data_out holds a word
//  ready_in   in   1             consumer accepts; pop when valid_out & ready_in
//  frame_err  out  1             1-cycle pulse: CS released mid-word
//  overflow   out  1             sticky: word dropped because FIFO full
//  ovf_clr    in   1             clears overflow (1-cycle pulse)
//  busy       out  1             CS asserted (synchronised) and frame in progress
// BEHAVIOUR
//  - Reset (a_rst=0, async): all outputs 0, FIFO empty, state IDLE, shift reg 0, bit_cnt 0.
//  - sck_in/cs_in/mosi_in each pass through a 2-FF synchroniser; SCK rise = sync & ~prev.
//  - FSM: IDLE -> SHIFT when cs_sync=0. SHIFT: on each SCK rise shift in mosi_sync (MSB first),
//    bit_cnt++. When bit_cnt reaches P_DATA_WIDTH: push word, bit_cnt=0, stay SHIFT (back-to-back
//    words within one CS window allowed). SHIFT -> IDLE on cs_sync=1.
//  - CS rise with 0<bit_cnt<P_DATA_WIDTH: partial word discarded, frame_err pulses 1 cycle.
//    CS rise with bit_cnt=0: no error. SCK edges while CS high are ignored.
//  - Same-cycle SCK rise and CS rise: CS wins; the edge is not sampled.
//  - Latency: valid_out rises 4 clk_100 cycles after the raw SCK rise of the last bit (FIFO empty).
//  - FIFO is show-ahead: data_out = head, stable while valid_out & ~ready_in.
//  - Push when full and no pop: word dropped, overflow set (sticky). Push+pop same cycle when
//    full: both succeed, no overflow. Pop when empty: ignored.
//  - ovf_clr clears overflow; if a drop occurs the same cycle, overflow stays 1.
//  - busy = (state==SHIFT).
// CONFIGURATION
//  SPI_RX_FRAME_CNT_EN defined: adds port frame_cnt out 16, count of words pushed into FIFO
//    (dropped words not counted), reset 0, wraps 16'hFFFF -> 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  config_pkg: P_DATA_WIDTH, P_RX_FIFO_DEPTH, typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t.
//  Sub-module spi_rx_fifo: show-ahead sync FIFO (wr_en/din/full, rd_en/dout/empty, count),
//  pointers with one extra wrap bit. Synchronisers, FSM, shifter and flags stay in spi_receiver.
// TESTING
//  1. CS low, send 8'hA5 at f_sck=12.5 MHz, CS high -> one word 8'hA5, valid_out 4 cycles after
//     last raw SCK rise, frame_err=0.
//  2. One CS window, words 8'h01,8'h02,8'h03, ready_in=1 -> popped in order, FIFO empty after.
//  3. ready_in=0, send 5 words (depth 4) -> first 4 held, 5th dropped, overflow=1; ovf_clr -> 0.
//  4. CS released after 5 bits of 8'hFF -> frame_err 1-cycle pulse, nothing pushed; next full
//     word 8'h3C received correctly.
//  5. Assert a_rst mid-word (after 3 bits) -> all outputs 0 immediately; after release, 8'h5A
//     received intact.
//  6. SPI_RX_FRAME_CNT_EN: 3 accepted + 1 dropped word -> frame_cnt=3; preload 16'hFFFF -> wraps 0.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration for the SPI receive path.
//   P_DATA_WIDTH     word width in bits
//   P_RX_FIFO_DEPTH  receive FIFO depth in words (power of 2, >= 2)
//   P_BIT_CNT_W      width of the per-word bit counter
//   rx_state_t       receiver FSM state
package config_pkg;

  localparam int unsigned P_DATA_WIDTH    = 8;
  localparam int unsigned P_RX_FIFO_DEPTH = 4;
  localparam int unsigned P_BIT_CNT_W     = $clog2(P_DATA_WIDTH + 1);

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous FIFO for received SPI words.
// The head word is visible on dout whenever empty is low; rd_en pops it.
// A write while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   wr_en, din, full write side
//   rd_en, dout, empty read side (dout is 0 while empty)
//   count            number of words stored
module spi_rx_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-0 receiver (MSB first) with a show-ahead output FIFO.
// CS/SCK/MOSI are asynchronous and each pass through a 2-FF synchroniser.
// Words are pushed into the FIFO and offered on a valid/ready interface.
// Optional feature macro: SPI_RX_FRAME_CNT_EN adds the frame_cnt output
// (16-bit wrapping count of words accepted into the FIFO).
// Ports:
//   clk_100, a_rst        clock and asynchronous active-low reset
//   sck_in, cs_in, mosi_in raw SPI inputs (CS active low)
//   data_out, valid_out   FIFO head word and its valid flag
//   ready_in              consumer accept; pops when valid_out & ready_in
//   frame_err             1-cycle pulse when CS is released mid-word
//   overflow, ovf_clr     sticky dropped-word flag and its clear
//   busy                  receiver is inside a CS window
//   frame_cnt             (optional) accepted word count
module spi_receiver
  import config_pkg::*;
(
  input  logic                    clk_100,
  input  logic                    a_rst,
  input  logic                    sck_in,
  input  logic                    cs_in,
  input  logic                    mosi_in,
  output logic [P_DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    frame_err,
  output logic                    overflow,
  input  logic                    ovf_clr,
  output logic                    busy
`ifdef SPI_RX_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int unsigned FifoAw = $clog2(P_RX_FIFO_DEPTH);
  localparam logic [P_BIT_CNT_W-1:0] LastBit = P_BIT_CNT_W'(P_DATA_WIDTH - 1);

  // Synchronisers
  logic sck_meta, sck_sync, sck_prev;
  logic cs_meta, cs_sync;
  logic mosi_meta, mosi_sync;
  logic sck_rise;

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      // CS resets to its inactive level so the FSM does not leave IDLE spuriously.
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sck_meta  <= sck_in;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= cs_in;
      cs_sync   <= cs_meta;
      mosi_meta <= mosi_in;
      mosi_sync <= mosi_meta;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;

  // FSM
  rx_state_t state_q, state_d;

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!cs_sync) state_d = RX_SHIFT;
      RX_SHIFT: if (cs_sync)  state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RX_SHIFT);
  end

  // Shifter and bit counter
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [P_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                    push_q, push_d;
  logic                    frame_err_q, frame_err_d;
  logic                    cs_release;
  logic                    sample;

  // CS release takes priority over an SCK edge seen in the same cycle.
  assign cs_release = (state_q == RX_SHIFT) & cs_sync;
  assign sample     = (state_q == RX_SHIFT) & ~cs_sync & sck_rise;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    if (cs_release) begin
      shift_d     = '0;
      bit_cnt_d   = '0;
      frame_err_d = (bit_cnt_q != '0);
    end else if (sample) begin
      shift_d = {shift_q[P_DATA_WIDTH-2:0], mosi_sync};
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d = '0;
        push_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // FIFO: push_q is one cycle after the word completes, and shift_q still holds
  // the word because SCK rises are at least four clk_100 cycles apart.
  logic              fifo_full;
  logic              fifo_empty;
  logic [FifoAw:0]   fifo_count;
  logic              pop;
  logic              drop;
  logic              unused_fifo_count;

  spi_rx_fifo #(
    .WIDTH (P_DATA_WIDTH),
    .DEPTH (P_RX_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100),
    .rst_n (a_rst),
    .wr_en (push_q),
    .din   (shift_q),
    .full  (fifo_full),
    .rd_en (ready_in),
    .dout  (data_out),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;
  assign valid_out = ~fifo_empty;
  assign pop       = valid_out & ready_in;
  assign drop      = push_q & fifo_full & ~pop;

  // Overflow flag: a drop wins over a simultaneous clear.
  logic overflow_q;

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

`ifdef SPI_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      frame_cnt_q <= '0;
    end else if (push_q && !drop) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: table-driven frames, directed corner
// sequences (latency, back-to-back, overflow, partial word, reset) and a
// randomized phase checked against a queue-based word model.
module tb_spi_receiver;

  logic       clk;
  logic       a_rst;
  logic       sck;
  logic       cs;
  logic       mosi;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overflow;
  logic       ovf_clr;
  logic       busy;
`ifdef SPI_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  logic ready_man;
  logic rand_en;
  logic rnd_bit;

  assign ready = rand_en ? rnd_bit : ready_man;

  spi_receiver dut (
    .clk_100   (clk),
    .a_rst     (a_rst),
    .sck_in    (sck),
    .cs_in     (cs),
    .mosi_in   (mosi),
    .data_out  (data_out),
    .valid_out (valid),
    .ready_in  (ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .busy      (busy)
`ifdef SPI_RX_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int fe_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Consumer and frame_err monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (a_rst && valid && ready) got_q.push_back(data_out);
    if (frame_err) fe_cnt++;
  end

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready_man = v;
  endtask

  // Mode 0, 12.5 MHz: data set while SCK low, sampled on SCK rise.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[7-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    #40;
  endtask

  task automatic cs_end();
    #40 cs = 1'b1;
    cycles(12);
  endtask

  task automatic check_queue(input string name);
    check({name, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_word"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  typedef struct {
    logic [7:0] word;
    int         nbits;
    int         exp_words;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] ow[5];
  bit   lat_v[4];
  int   fe0;

  initial begin
    a_rst = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    ready_man = 1'b0; ovf_clr = 1'b0; rand_en = 1'b0;

    cycles(3);
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) a_rst = 1'b1;
    cycles(4);
    check("idle_busy", busy, 0);

    // Table-driven single-window frames, consumer always ready.
    vecs[0] = '{word: 8'hA5, nbits: 8, exp_words: 1, exp_err: 0};
    vecs[1] = '{word: 8'h00, nbits: 8, exp_words: 1, exp_err: 0};
    vecs[2] = '{word: 8'hFF, nbits: 8, exp_words: 1, exp_err: 0};
    vecs[3] = '{word: 8'h80, nbits: 1, exp_words: 0, exp_err: 1};
    vecs[4] = '{word: 8'h7E, nbits: 7, exp_words: 0, exp_err: 1};
    vecs[5] = '{word: 8'h5A, nbits: 0, exp_words: 0, exp_err: 0};
    set_ready(1'b1);
    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      fe0 = fe_cnt;
      cs_start();
      check("vec_busy", busy, 1);
      send_bits(vecs[v].word, vecs[v].nbits);
      cs_end();
      check("vec_nwords", got_q.size(), vecs[v].exp_words);
      check("vec_ferr", fe_cnt - fe0, vecs[v].exp_err);
      if (vecs[v].exp_words == 1 && got_q.size() == 1)
        check("vec_word", {24'd0, got_q[0]}, {24'd0, vecs[v].word});
    end

    // Latency: valid 4 clk cycles after the raw SCK rise of the last bit.
    set_ready(1'b0);
    got_q.delete();
    fe0 = fe_cnt;
    cs_start();
    send_bits(8'hA5, 7);
    mosi = 1'b1;
    #40;
    @(posedge clk);
    #1 sck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 lat_v[k] = valid;
    end
    check("lat_3", lat_v[2], 0);
    check("lat_4", lat_v[3], 1);
    #20 sck = 1'b0;
    check("lat_data", data_out, 8'hA5);
    cs_end();
    check("lat_ferr", fe_cnt - fe0, 0);
    check("lat_busy", busy, 0);
    set_ready(1'b1);
    cycles(3);
    exp_q = '{8'hA5};
    check_queue("lat_pop");

    // Back-to-back words in one CS window.
    got_q.delete();
    cs_start();
    send_bits(8'h01, 8);
    send_bits(8'h02, 8);
    send_bits(8'h03, 8);
    cs_end();
    exp_q = '{8'h01, 8'h02, 8'h03};
    check_queue("b2b");
    check("b2b_empty", valid, 0);

    // Overflow: 5 words into depth 4 with consumer stalled.
    ow = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    set_ready(1'b0);
    got_q.delete();
    check("ovf_pre", overflow, 0);
    cs_start();
    for (int i = 0; i < 5; i++) send_bits(ow[i], 8);
    cs_end();
    check("ovf_set", overflow, 1);
    check("ovf_head", data_out, 8'h11);
    cycles(5);
    check("ovf_head_stable", data_out, 8'h11);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    set_ready(1'b1);
    cycles(8);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_queue("ovf_drain");

    // Partial word then a good word.
    got_q.delete();
    fe0 = fe_cnt;
    cs_start();
    send_bits(8'hFF, 5);
    cs_end();
    check("part_ferr", fe_cnt - fe0, 1);
    check("part_nopush", got_q.size(), 0);
    cs_start();
    send_bits(8'h3C, 8);
    cs_end();
    check("part_ferr2", fe_cnt - fe0, 1);
    exp_q = '{8'h3C};
    check_queue("part_next");

    // Randomized windows against the word-queue model.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    begin
      int exp_fe = 0;
      logic [7:0] w;
      rand_en = 1'b1;
      for (int n = 0; n < 25; n++) begin
        int k = $urandom_range(1, 3);
        int tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        cs_start();
        for (int j = 0; j < k; j++) begin
          w = 8'($urandom);
          exp_q.push_back(w);
          send_bits(w, 8);
        end
        if (tail != 0) begin
          send_bits(8'($urandom), tail);
          exp_fe++;
        end
        cs_end();
      end
      rand_en = 1'b0;
      cycles(10);
      check_queue("rand");
      check("rand_ferr", fe_cnt - fe0, exp_fe);
      check("rand_ovf", overflow, 0);
    end

    // Reset mid-word with a word already buffered.
    set_ready(1'b0);
    got_q.delete();
    cs_start();
    send_bits(8'hC3, 8);
    send_bits(8'hE0, 3);
    cycles(2);
    check("mrst_pre_valid", valid, 1);
    check("mrst_pre_busy", busy, 1);
    a_rst = 1'b0;
    #1;
    check("mrst_valid", valid, 0);
    check("mrst_data", data_out, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_ferr", frame_err, 0);
    cs = 1'b1;
    cycles(3);
    @(negedge clk) a_rst = 1'b1;
    cycles(3);
    set_ready(1'b1);
    fe0 = fe_cnt;
    cs_start();
    send_bits(8'h5A, 8);
    cs_end();
    exp_q = '{8'h5A};
    check_queue("mrst_next");
    check("mrst_ferr2", fe_cnt - fe0, 0);

`ifdef SPI_RX_FRAME_CNT_EN
    // One word accepted since reset; 4 more accepted and 1 dropped.
    check("fcnt_1", frame_cnt, 1);
    set_ready(1'b0);
    cs_start();
    for (int i = 0; i < 5; i++) send_bits(ow[i], 8);
    cs_end();
    check("fcnt_5", frame_cnt, 5);
    set_ready(1'b1);
    cycles(8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
